// File: rtl/conv1_pkg.sv
// conv1_pkg: shared FSM state type and default sizes for the conv1 SRAM reader.
package conv1_pkg;

  localparam int CONV1_DW = 192;
  localparam int CONV1_AW = 10;
  localparam int CONV1_DP = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } conv1_state_t;

endpackage

// File: rtl/conv1_rd_fifo.sv
// conv1_rd_fifo: 2-entry read-data FIFO between the SRAM and the PE array.
// The head entry is never overwritten by a push, so it stays stable while
// the consumer stalls.
module conv1_rd_fifo
  import conv1_pkg::*;
#(
  parameter int DW = CONV1_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [1:0]    count,
  output logic [DW-1:0] head
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;

  assign head = mem[rd_ptr];

  // Storage, pointers and occupancy; simultaneous push and pop keep the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/conv1_sram_reader.sv
// conv1_sram_reader: burst reader that streams consecutive SRAM words
// (wrapping modulo DP) to the PE array through a 2-entry FIFO.
// The SRAM word addressed during a chip-select cycle is captured into the
// FIFO at the end of that cycle, so at most one read is ever in flight.
// Optional build macro CONV1_RD_STALL_CNT_EN adds the 16-bit stall_cnt port.
module conv1_sram_reader
  import conv1_pkg::*;
#(
  parameter int DW = CONV1_DW,
  parameter int AW = CONV1_AW,
  parameter int DP = CONV1_DP
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
  output logic          sram_cs,
  output logic          sram_we,
  output logic          sram_wem,
  output logic [AW-1:0] sram_addr,
  input  logic [DW-1:0] sram_dout,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          done
`ifdef CONV1_RD_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  conv1_state_t state;
  logic [AW:0]  len_q;
  logic [AW:0]  issued;
  logic [AW:0]  sent;
  logic [1:0]   fifo_count;
  logic         pop;
  logic [2:0]   occ_after;
  logic         can_issue;

  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return (a == AW'(DP - 1)) ? '0 : a + AW'(1);
  endfunction

  assign sram_we   = 1'b0;
  assign sram_wem  = 1'b0;
  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_last  = out_valid & (sent == len_q - (AW+1)'(1));
  assign busy      = (state != ST_IDLE);

  // FIFO occupancy after this edge, counting the word now being read.
  assign occ_after = {1'b0, fifo_count} + {2'b00, sram_cs} - {2'b00, pop};
  assign can_issue = (issued < len_q) && (occ_after < 3'd2);

  conv1_rd_fifo #(.DW(DW)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (sram_cs),
    .push_data (sram_dout),
    .pop       (pop),
    .count     (fifo_count),
    .head      (out_data)
  );

  // Burst FSM: latches the request, issues reads while the FIFO has room,
  // and pulses done after the last word has been handed over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      issued    <= '0;
      sent      <= '0;
      sram_cs   <= 1'b0;
      sram_addr <= '0;
      done      <= 1'b0;
    end else begin
      sram_cs <= 1'b0;
      done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              len_q     <= len;
              issued    <= (AW+1)'(1);
              sent      <= '0;
              sram_cs   <= 1'b1;
              sram_addr <= base_addr;
              state     <= (len == (AW+1)'(1)) ? ST_DRAIN : ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (can_issue) begin
            sram_cs   <= 1'b1;
            sram_addr <= addr_inc(sram_addr);
            issued    <= issued + (AW+1)'(1);
            if (issued + (AW+1)'(1) == len_q) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (pop && out_last) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (pop) begin
        sent <= sent + (AW+1)'(1);
      end
    end
  end

`ifdef CONV1_RD_STALL_CNT_EN
  // Saturating count of cycles where a word waits on the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'd0;
    end else if (state == ST_IDLE && start) begin
      stall_cnt <= 16'd0;
    end else if (out_valid && !out_ready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv1_sram_reader.sv
// tb_conv1_sram_reader: directed bench for conv1_sram_reader with a
// queue-based burst model and a per-cycle compare process.
module tb_conv1_sram_reader;

  localparam int DW = 192;
  localparam int AW = 10;
  localparam int DP = 32;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_word_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          sram_cs;
  logic          sram_we;
  logic          sram_wem;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dout;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;
`ifdef CONV1_RD_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mem [DP];

  exp_word_t     word_q [$];
  int            addr_q [$];
  int            cs_log [$];
  logic [DW-1:0] xfer_log [$];
  logic          m_busy     = 1'b0;
  logic          m_done     = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  int            outstanding = 0;

  conv1_sram_reader #(.DW(DW), .AW(AW), .DP(DP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .sram_cs   (sram_cs),
    .sram_we   (sram_we),
    .sram_wem  (sram_wem),
    .sram_addr (sram_addr),
    .sram_dout (sram_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
`ifdef CONV1_RD_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Word stored at each SRAM address: distinct per address in every lane.
  function automatic logic [DW-1:0] word_of(input int a);
    logic [31:0] w;
    w = 32'hC0DE_0000 | a;
    return {6{w}};
  endfunction

  // SRAM macro: the addressed word is presented during the chip-select cycle.
  assign sram_dout = sram_cs ? mem[sram_addr[4:0]] : '0;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic checkOutputBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic checkOutputInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Burst model and per-cycle comparison, sampled mid-cycle.
  always @(negedge clk) begin
    logic n_busy;
    logic n_done;
    exp_word_t e;
    if (!rst_n) begin
      word_q.delete();
      addr_q.delete();
      m_busy      = 1'b0;
      m_done      = 1'b0;
      prev_stall  = 1'b0;
      outstanding = 0;
    end else begin
      checkOutputBit("busy", busy, m_busy);
      checkOutputBit("done", done, m_done);
      checkOutputBit("sram_we", sram_we | sram_wem, 1'b0);
      if (sram_cs) begin
        cs_log.push_back(int'(sram_addr));
        if (addr_q.size() == 0) checkOutputInt("cs_unexpected", 1, 0);
        else checkOutputInt("sram_addr", int'(sram_addr), addr_q.pop_front());
        outstanding++;
      end
      if (prev_stall) begin
        checkOutputBit("hold_valid", out_valid, 1'b1);
        checkOutput("hold_data", out_data, prev_data);
      end
      if (out_valid) begin
        if (word_q.size() == 0) checkOutputInt("valid_unexpected", 1, 0);
        else begin
          checkOutput("out_data", out_data, word_q[0].data);
          checkOutputBit("out_last", out_last, word_q[0].last);
        end
      end else begin
        checkOutputBit("out_last_idle", out_last, 1'b0);
      end
      n_busy = m_busy;
      n_done = 1'b0;
      if (out_valid && out_ready && word_q.size() != 0) begin
        xfer_log.push_back(out_data);
        e = word_q.pop_front();
        if (e.last) begin
          n_busy = 1'b0;
          n_done = 1'b1;
        end
        outstanding--;
      end
      checkOutputBit("occupancy_le2", (outstanding <= 2), 1'b1);
      if (start && !m_busy) begin
        if (len == '0) n_done = 1'b1;
        else begin
          n_busy = 1'b1;
          for (int k = 0; k < int'(len); k++) begin
            addr_q.push_back((int'(base_addr) + k) % DP);
            word_q.push_back('{data: word_of((int'(base_addr) + k) % DP), last: (k == int'(len) - 1)});
          end
        end
      end
      m_busy     = n_busy;
      m_done     = n_done;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // Start pulse driven in the cycle before edge 0; returns early in cycle 1.
  task automatic applyStimulus(input int b, input int l);
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = AW'(b);
    len       = (AW+1)'(l);
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutputBit("done_timeout", 1'b0, 1'b1);
  endtask

  task automatic clearLogs();
    cs_log.delete();
    xfer_log.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit            exp_cs    [6] = '{1, 1, 1, 1, 0, 0};
    bit            exp_valid [6] = '{0, 1, 1, 1, 1, 0};
    bit            exp_last  [6] = '{0, 0, 0, 0, 1, 0};
    bit            exp_done  [6] = '{0, 0, 0, 0, 0, 1};
    int            wrap_addr [5] = '{30, 31, 0, 1, 2};
    logic [DW-1:0] w;
    int            n;

    for (int a = 0; a < DP; a++) mem[a] = word_of(a);
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b0;

    // Reset values
    @(negedge clk);
    checkOutputBit("rst_cs", sram_cs, 1'b0);
    checkOutputInt("rst_addr", int'(sram_addr), 0);
    checkOutputBit("rst_valid", out_valid, 1'b0);
    checkOutputBit("rst_last", out_last, 1'b0);
    checkOutputBit("rst_busy", busy, 1'b0);
    checkOutputBit("rst_done", done, 1'b0);
    checkOutput("rst_data", out_data, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // base 0, len 4, ready high: cycle-exact trace
    $display("[TB] burst base=0 len=4");
    out_ready = 1'b1;
    clearLogs();
    applyStimulus(0, 4);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checkOutputBit("trace_cs", sram_cs, exp_cs[c]);
      if (exp_cs[c]) checkOutputInt("trace_addr", int'(sram_addr), c);
      checkOutputBit("trace_valid", out_valid, exp_valid[c]);
      checkOutputBit("trace_last", out_last, exp_last[c]);
      checkOutputBit("trace_done", done, exp_done[c]);
    end

    // Wrap from address 31 to 0
    $display("[TB] burst base=30 len=5");
    clearLogs();
    applyStimulus(30, 5);
    waitDone(40);
    checkOutputInt("wrap_count", cs_log.size(), 5);
    for (int i = 0; i < 5 && i < cs_log.size(); i++) checkOutputInt("wrap_addr", cs_log[i], wrap_addr[i]);
    checkOutputInt("wrap_xfers", xfer_log.size(), 5);
    w = {6{32'hC0DE_001F}};
    if (xfer_log.size() > 1) checkOutput("wrap_word1", xfer_log[1], w);
    w = {6{32'hC0DE_0000}};
    if (xfer_log.size() > 2) checkOutput("wrap_word2", xfer_log[2], w);

    // len 8 with out_ready toggling; a start mid-burst must be ignored
    $display("[TB] burst base=10 len=8 toggling ready");
    clearLogs();
    out_ready = 1'b1;
    applyStimulus(10, 8);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        n = 1;
        break;
      end
      @(posedge clk); #1;
      out_ready = ~out_ready;
      if (i == 3) begin start = 1'b1; base_addr = AW'(0); len = (AW+1)'(3); end
      if (i == 4) start = 1'b0;
    end
    checkOutputInt("toggle_done_seen", n, 1);
    checkOutputInt("toggle_xfers", xfer_log.size(), 8);
    checkOutputInt("toggle_reads", cs_log.size(), 8);
    if (cs_log.size() > 0) checkOutputInt("toggle_first_addr", cs_log[0], 10);
    w = {6{32'hC0DE_0011}};
    if (xfer_log.size() > 7) checkOutput("toggle_word7", xfer_log[7], w);

    // len 0: done next cycle, no read, never busy
    $display("[TB] zero-length start");
    out_ready = 1'b1;
    @(posedge clk); #1;
    clearLogs();
    applyStimulus(7, 0);
    @(negedge clk);
    checkOutputBit("len0_done", done, 1'b1);
    checkOutputBit("len0_busy", busy, 1'b0);
    @(negedge clk);
    checkOutputBit("len0_done_clear", done, 1'b0);
    repeat (3) @(negedge clk);
    checkOutputInt("len0_reads", cs_log.size(), 0);

    // Reset on the third delivered word of a 10-word burst
    $display("[TB] reset mid-burst");
    applyStimulus(0, 10);
    n = 0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) n++;
    end
    rst_n = 1'b0;
    #1;
    checkOutputBit("mid_rst_cs", sram_cs, 1'b0);
    checkOutputInt("mid_rst_addr", int'(sram_addr), 0);
    checkOutputBit("mid_rst_valid", out_valid, 1'b0);
    checkOutputBit("mid_rst_busy", busy, 1'b0);
    checkOutputBit("mid_rst_done", done, 1'b0);
    checkOutput("mid_rst_data", out_data, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    clearLogs();
    applyStimulus(5, 2);
    waitDone(20);
    checkOutputInt("restart_reads", cs_log.size(), 2);
    if (cs_log.size() > 1) checkOutputInt("restart_addr1", cs_log[1], 6);
    w = {6{32'hC0DE_0005}};
    if (xfer_log.size() > 0) checkOutput("restart_word0", xfer_log[0], w);
    w = {6{32'hC0DE_0006}};
    if (xfer_log.size() > 1) checkOutput("restart_word1", xfer_log[1], w);

    // Consumer stalls for the first three valid cycles
    $display("[TB] stalled burst base=8 len=4");
    clearLogs();
    out_ready = 1'b0;
    applyStimulus(8, 4);
    repeat (4) @(negedge clk);
    @(posedge clk); #1 out_ready = 1'b1;
    waitDone(30);
    checkOutputInt("stall_xfers", xfer_log.size(), 4);
`ifdef CONV1_RD_STALL_CNT_EN
    checkOutputInt("stall_cnt", int'(stall_cnt), 3);
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
